// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave -- SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) that runs entirely
// in the fast_clk domain. sclk, cs_n and mosi are oversampled through a
// SYNC_STAGES-deep synchronizer, and the bus edges are decoded in fast_clk.
//
// Parameters
//   DATA_WIDTH   bits per SPI word (>= 2)
//   SYNC_STAGES  synchronizer depth, 2 or 3
//
// Ports
//   fast_clk    in   system clock; all state updates on its rising edge
//   rst         in   synchronous, active-high reset
//   sclk        in   SPI clock from the master (asynchronous)
//   cs_n        in   active-low chip select (asynchronous)
//   mosi        in   serial data from the master (asynchronous)
//   miso        out  serial data to the master (0 while idle)
//   tx_data     in   word to transmit
//   tx_load     in   strobe: write tx_data into the TX holding register
//   tx_empty    out  holding register has no unsent word
//   rx_data     out  last complete received word
//   rx_valid    out  rx_data holds an unacknowledged word
//   rx_overrun  out  (SPI_SLAVE_OVERRUN_EN only) word overwritten unacknowledged
//   rx_ack      in   strobe: clears rx_valid (and rx_overrun)
//
// Build option: define SPI_SLAVE_OVERRUN_EN to add the rx_overrun port.
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  fast_clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic                  rx_overrun,
`endif
  input  logic                  rx_ack
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // ---------------- synchronizers and edge decode ----------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;
  logic                   mosi_q;

  // Decoded edges are registered together with the mosi sample so that the
  // bit shifted in is the one present when the sclk rise was detected.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      sclk_rise_q <=  sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] &  sclk_dly_q;
      cs_fall_q   <= ~cs_sync_q[SYNC_STAGES-1]   &  cs_dly_q;
      cs_rise_q   <=  cs_sync_q[SYNC_STAGES-1]   & ~cs_dly_q;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  // ---------------- word FSM ----------------
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic                  tx_empty_q, tx_empty_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_reload;
  logic                  word_done;

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    word_done  = 1'b0;
    tx_reload  = tx_empty_q ? '0 : tx_hold_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_reload;
        end
      end
      SHIFT: begin
        if (cs_rise_q) begin
          state_d = IDLE;
        end else if (sclk_rise_q) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_q};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall_q && (cnt_q != '0)) begin
          // With the count at zero the MSB of a freshly reloaded word is
          // already on miso; the fall that ends the previous word must not
          // shift it away.
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      DONE: begin
        word_done  = 1'b1;
        state_d    = cs_rise_q ? IDLE : SHIFT;
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
        tx_shift_d = tx_reload;
        tx_empty_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A completing word wins over an acknowledge in the same cycle.
    if (rx_ack && !word_done) rx_valid_d = 1'b0;
    // Applied after the DONE reload so a load in that cycle feeds the next word.
    if (tx_load) begin
      tx_hold_d  = tx_data;
      tx_empty_d = 1'b0;
    end
  end

  assign miso     = (state_q != IDLE) & tx_shift_q[DATA_WIDTH-1];
  assign tx_empty = tx_empty_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_overrun_q, rx_overrun_d;

  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (rx_ack)                        rx_overrun_d = 1'b0;
    else if (word_done && rx_valid_q)  rx_overrun_d = 1'b1;
  end

  always_ff @(posedge fast_clk) begin
    if (rst) rx_overrun_q <= 1'b0;
    else     rx_overrun_q <= rx_overrun_d;
  end

  assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int DW   = 8;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic          fast_clk = 1'b0;
  logic          rst      = 1'b1;
  logic          sclk     = 1'b0;
  logic          cs_n     = 1'b1;
  logic          mosi     = 1'b0;
  logic          tx_load  = 1'b0;
  logic          rx_ack   = 1'b0;
  logic [DW-1:0] tx_data  = '0;
  logic          miso, tx_empty, rx_valid;
  logic [DW-1:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic          rx_overrun;
`endif

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
    .fast_clk  (fast_clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_empty  (tx_empty),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_overrun(rx_overrun),
`endif
    .rx_ack    (rx_ack)
  );

  always #5 fast_clk = ~fast_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The driver knows when it makes each SPI event happen and posts the
  // fast_clk cycle at which its effect must become visible; the model then
  // applies word-level rules at those cycles.
  int            cyc = 0;
  bit            ev_start[int];
  bit            ev_end[int];
  logic [DW-1:0] ev_done[int];
  logic [DW-1:0] m_hold = '0, m_tx = '0, m_rx_data = '0;
  logic          m_empty = 1'b1, m_valid = 1'b0, m_ov = 1'b0, m_active = 1'b0;

  always @(posedge fast_clk) begin : model
    logic [DW-1:0] reload;
    cyc = cyc + 1;
    if (rst) begin
      m_hold = '0; m_tx = '0; m_rx_data = '0;
      m_empty = 1'b1; m_valid = 1'b0; m_ov = 1'b0; m_active = 1'b0;
      ev_start.delete(); ev_end.delete(); ev_done.delete();
    end else begin
      reload = m_empty ? '0 : m_hold;
      if (ev_start.exists(cyc)) begin
        m_active = 1'b1;
        m_tx     = reload;
        ev_start.delete(cyc);
      end
      if (ev_end.exists(cyc)) begin
        m_active = 1'b0;
        ev_end.delete(cyc);
      end
      if (ev_done.exists(cyc)) begin
        if (m_valid && !rx_ack) m_ov = 1'b1;
        m_rx_data = ev_done[cyc];
        m_valid   = 1'b1;
        m_tx      = reload;
        m_empty   = 1'b1;
        ev_done.delete(cyc);
      end else if (rx_ack) begin
        m_valid = 1'b0;
      end
      if (rx_ack) m_ov = 1'b0;
      if (tx_load) begin
        m_hold  = tx_data;
        m_empty = 1'b0;
      end
    end
  end

  always @(negedge fast_clk) begin : compare
    check("rx_valid", rx_valid, m_valid);
    check("rx_data", rx_data, m_rx_data);
    check("tx_empty", tx_empty, m_empty);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("rx_overrun", rx_overrun, m_ov);
`endif
    if (!m_active) check("miso_idle", miso, 1'b0);
  end

  // ---------------- driver ----------------
  int            bitcnt = 0;
  logic [DW-1:0] drv_acc = '0;
  logic [DW-1:0] miso_word = '0;
  logic          ack_at_done = 1'b0, load_at_done = 1'b0;
  logic [DW-1:0] load_val = '0;
  bit            measure = 1'b0;
  int            lat_j = -1;

  task automatic pulse(input logic ack, input logic ld, input logic [DW-1:0] d);
    @(negedge fast_clk);
    rx_ack = ack; tx_load = ld; tx_data = d;
    @(negedge fast_clk);
    rx_ack = 1'b0; tx_load = 1'b0;
  endtask

  task automatic frame_begin();
    @(negedge fast_clk);
    cs_n = 1'b0;
    ev_start[cyc + S + 2] = 1'b1;
    bitcnt = 0;
    repeat (HALF) @(negedge fast_clk);
  endtask

  task automatic frame_end();
    @(negedge fast_clk);
    cs_n = 1'b1;
    ev_end[cyc + S + 2] = 1'b1;
    bitcnt = 0;
    repeat (HALF + S + 2) @(negedge fast_clk);
  endtask

  task automatic xfer_bit(input logic b);
    logic last;
    @(negedge fast_clk);
    mosi = b;
    repeat (HALF - 1) @(negedge fast_clk);
    // master samples miso just before the rising edge
    check("miso_bit", miso, m_tx[DW-1-bitcnt]);
    miso_word[DW-1-bitcnt] = miso;
    sclk    = 1'b1;
    drv_acc = {drv_acc[DW-2:0], b};
    last    = (bitcnt == DW - 1);
    if (last) ev_done[cyc + S + 3] = drv_acc;
    bitcnt = last ? 0 : bitcnt + 1;
    for (int j = 1; j <= HALF; j++) begin
      @(negedge fast_clk);
      rx_ack  = last && ack_at_done  && (j == S + 2);
      tx_load = last && load_at_done && (j == S + 2);
      if (tx_load) tx_data = load_val;
      if (measure && last && lat_j < 0 && rx_valid) lat_j = j;
    end
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) xfer_bit(w[i]);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] w;
    logic [DW-1:0] w55;
    int            nw, k;

    rst = 1'b1;
    repeat (4) @(negedge fast_clk);
    check("rst_miso", miso, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_empty", tx_empty, 1'b1);
    @(negedge fast_clk);
    rst = 1'b0;
    repeat (3) @(negedge fast_clk);

    // load 0xA5, receive 0x3C
    pulse(1'b0, 1'b1, 8'hA5);
    check("t1_tx_empty_loaded", tx_empty, 1'b0);
    measure = 1'b1;
    frame_begin();
    send_word(8'h3C);
    measure = 1'b0;
    frame_end();
    check("t1_miso_word", miso_word, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rx_valid", rx_valid, 1'b1);
    check("t1_tx_empty", tx_empty, 1'b1);
    check("t1_latency", lat_j - 1, S + 2);

    // back-to-back words, no acknowledge in between
    pulse(1'b1, 1'b0, '0);
    check("t2_acked", rx_valid, 1'b0);
    frame_begin();
    send_word(8'h81);
    send_word(8'h7E);
    frame_end();
    check("t2_rx_data", rx_data, 8'h7E);
    check("t2_rx_valid", rx_valid, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t2_overrun", rx_overrun, 1'b1);
`endif
    pulse(1'b1, 1'b0, '0);
    check("t2_ack_valid", rx_valid, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t2_ack_overrun", rx_overrun, 1'b0);
`endif

    // aborted frame after 5 bits, then a full 0x55 frame
    w55 = 8'h55;
    frame_begin();
    for (int i = DW - 1; i >= DW - 5; i--) xfer_bit(w55[i]);
    frame_end();
    check("t3_partial_valid", rx_valid, 1'b0);
    check("t3_partial_data", rx_data, 8'h7E);
    frame_begin();
    send_word(8'h55);
    frame_end();
    check("t3_rx_data", rx_data, 8'h55);
    check("t3_rx_valid", rx_valid, 1'b1);
    pulse(1'b1, 1'b0, '0);

    // nothing loaded: miso stays low
    check("t4_tx_empty", tx_empty, 1'b1);
    w = DW'($urandom);
    frame_begin();
    send_word(w);
    frame_end();
    check("t4_miso_zero", miso_word, 8'h00);
    check("t4_rx_data", rx_data, w);
    pulse(1'b1, 1'b0, '0);

    // reset in the middle of a frame
    pulse(1'b0, 1'b1, 8'hC3);
    frame_begin();
    for (int i = 0; i < 4; i++) xfer_bit(1'b1);
    @(negedge fast_clk);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; bitcnt = 0;
    repeat (S + 3) @(negedge fast_clk);
    check("t5_rst_miso", miso, 1'b0);
    check("t5_rst_rx_valid", rx_valid, 1'b0);
    check("t5_rst_rx_data", rx_data, 8'h00);
    check("t5_rst_tx_empty", tx_empty, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t5_rst_overrun", rx_overrun, 1'b0);
`endif
    @(negedge fast_clk);
    rst = 1'b0;
    repeat (3) @(negedge fast_clk);
    frame_begin();
    send_word(8'hF0);
    frame_end();
    check("t5_rx_data", rx_data, 8'hF0);
    check("t5_rx_valid", rx_valid, 1'b1);
    check("t5_miso_zero", miso_word, 8'h00);

    // acknowledge and tx_load in the same cycle as word completion
    ack_at_done = 1'b1; load_at_done = 1'b1; load_val = 8'h3A;
    frame_begin();
    send_word(8'h99);
    ack_at_done = 1'b0; load_at_done = 1'b0;
    frame_end();
    check("t6_rx_valid", rx_valid, 1'b1);
    check("t6_rx_data", rx_data, 8'h99);
    check("t6_tx_empty", tx_empty, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t6_overrun", rx_overrun, 1'b0);
`endif
    pulse(1'b1, 1'b0, '0);
    frame_begin();
    send_word(8'h11);
    frame_end();
    check("t6_next_miso", miso_word, 8'h3A);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 1) == 1) pulse(1'b0, 1'b1, DW'($urandom));
      if ($urandom_range(0, 2) == 0) pulse(1'b1, 1'b0, '0);
      frame_begin();
      nw = $urandom_range(1, 3);
      for (int n = 0; n < nw; n++) begin
        ack_at_done  = ($urandom_range(0, 3) == 0);
        load_at_done = ($urandom_range(0, 2) == 0);
        load_val     = DW'($urandom);
        send_word(DW'($urandom));
      end
      ack_at_done = 1'b0; load_at_done = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, DW - 1);
        for (int i = 0; i < k; i++) xfer_bit(1'($urandom));
      end
      frame_end();
    end

    repeat (4) @(negedge fast_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
